// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath strobe bundle; master = controller, slave = datapath side.
// Perf counter outputs exist only when MULTICYCLE_CTRL_PERF_EN is defined.
interface multicycle_ctrl_if;
  logic [31:0] ins;
  logic        zero;
  logic        mem_ready;
  logic        i_req;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        reg_write;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        illegal;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;

  modport master (
    input  ins, zero, mem_ready,
    output i_req, ir_we, pc_we, pc_sel, reg_write, alu_src, alu_op,
           mem_read, mem_write, wb_sel, state, illegal, cyc_cnt, ret_cnt
  );
  modport slave (
    output ins, zero, mem_ready,
    input  i_req, ir_we, pc_we, pc_sel, reg_write, alu_src, alu_op,
           mem_read, mem_write, wb_sel, state, illegal, cyc_cnt, ret_cnt
  );
`else
  modport master (
    input  ins, zero, mem_ready,
    output i_req, ir_we, pc_we, pc_sel, reg_write, alu_src, alu_op,
           mem_read, mem_write, wb_sel, state, illegal
  );
  modport slave (
    output ins, zero, mem_ready,
    input  i_req, ir_we, pc_we, pc_sel, reg_write, alu_src, alu_op,
           mem_read, mem_write, wb_sel, state, illegal
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I subset sequencer; MULTICYCLE_CTRL_PERF_EN adds cycle/retire counters.
// Zero-wait latency R/I/sw/jal 4, lw 5, beq 3; FETCH and MEM stall while mem_ready is low.
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t st;
  logic   illegal_q;

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       f3_alu;
  logic       is_r, is_i, is_lw, is_sw, is_beq, is_jal, legal;
  logic [2:0] alu_fn;
  logic       unused_fields;

  assign opc = bus.ins[6:0];
  assign f3  = bus.ins[14:12];
  assign f7  = bus.ins[31:25];
  assign unused_fields = ^{bus.ins[24:15], bus.ins[11:7]};

  assign f3_alu = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
  // funct7 = 0100000 is only meaningful as sub
  assign is_r   = (opc == 7'b0110011) && f3_alu &&
                  ((f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000)));
  assign is_i   = (opc == 7'b0010011) && f3_alu;
  assign is_lw  = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_sw  = (opc == 7'b0100011) && (f3 == 3'b010);
  assign is_beq = (opc == 7'b1100011) && (f3 == 3'b000);
  assign is_jal = (opc == 7'b1101111);
  assign legal  = is_r | is_i | is_lw | is_sw | is_beq | is_jal;

  always_comb begin
    case (f3)
      3'b111:  alu_fn = 3'b000;
      3'b110:  alu_fn = 3'b001;
      3'b010:  alu_fn = 3'b111;
      default: alu_fn = (is_r && f7[5]) ? 3'b110 : 3'b010;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      case (st)
        FETCH:  if (bus.mem_ready) st <= DECODE;
        DECODE: begin
          if (legal) begin
            st <= EXEC;
          end else begin
            st        <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          if (is_beq)              st <= FETCH;
          else if (is_lw || is_sw) st <= MEM;
          else                     st <= WB;
        end
        MEM:    if (bus.mem_ready) st <= is_lw ? WB : FETCH;
        WB:     st <= FETCH;
        TRAP:   st <= TRAP;
        default: st <= FETCH;
      endcase
    end
  end

  logic       i_req, ir_we, pc_we, reg_write, alu_src, mem_read, mem_write;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] alu_op;

  // Strobes are forced idle while rst is held, even though st already reads FETCH.
  always_comb begin
    i_req     = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 3'b010;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_sel    = 2'b00;
    if (!rst) begin
      case (st)
        FETCH: begin
          i_req = 1'b1;
          ir_we = bus.mem_ready;
        end
        EXEC: begin
          alu_src = is_i | is_lw | is_sw;
          if (is_beq) begin
            alu_op = 3'b110;
            pc_we  = 1'b1;
            pc_sel = bus.zero ? 2'b01 : 2'b00;
          end else if (is_r || is_i) begin
            alu_op = alu_fn;
          end
        end
        MEM: begin
          mem_read  = is_lw;
          mem_write = is_sw;
          pc_we     = is_sw && bus.mem_ready;
        end
        WB: begin
          reg_write = 1'b1;
          pc_we     = 1'b1;
          wb_sel    = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
          pc_sel    = is_jal ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.i_req     = i_req;
  assign bus.ir_we     = ir_we;
  assign bus.pc_we     = pc_we;
  assign bus.pc_sel    = pc_sel;
  assign bus.reg_write = reg_write;
  assign bus.alu_src   = alu_src;
  assign bus.alu_op    = alu_op;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.wb_sel    = wb_sel;
  assign bus.state     = st;
  assign bus.illegal   = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] ret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      if (st != TRAP) cyc_q <= cyc_q + 32'd1;
      if (pc_we)      ret_q <= ret_q + 32'd1;
    end
  end

  assign bus.cyc_cnt = cyc_q;
  assign bus.ret_cnt = ret_q;
`else
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared RV32I datapath: fetch (PC register + instruction memory), decode (register file + immediate generator), the single ALU, data memory and writeback.
- Supports the subset R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, lw, sw, beq and jal.
- Drives every enable and select line, one instruction at a time, with a ready handshake on both memory accesses.
- Sits between the instruction register and the datapath strobes; it contains no datapath storage.

Parameters:
- RESET_STATE, 0, state encoding entered on reset (FETCH). Fixed; exposed for bench visibility only.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ins  in  32  instruction held in the instruction register (valid from DECODE onward)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory acknowledge (instruction or data access)
- i_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load
- pc_we  out  1  PC register write enable
- pc_sel  out  2  next PC: 00 PC+4, 01 branch target, 10 jal target
- reg_write  out  1  register file write enable
- alu_src  out  1  ALU operand B: 0 = rd2, 1 = immOut
- alu_op  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- mem_read  out  1  data memory read
- mem_write  out  1  data memory write
- wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4
- state  out  3  current state (debug)
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - state = FETCH; all strobes = 0; pc_sel = wb_sel = 00; alu_op = 010; illegal = 0.
  - An access in flight is abandoned. The PC is not written.
- Outputs are combinational from state and ins (Moore style with decode). Strobes are 0 in every state except where listed below.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH on the next edge.
- FETCH:
  - i_req = 1.
  - ir_we = mem_ready.
  - Advance to DECODE when mem_ready = 1; otherwise hold.
- DECODE:
  - One cycle, no strobes.
  - Legal instruction: go to EXEC.
  - Unsupported opcode or funct: go to TRAP.
- EXEC:
  - alu_src = 1 for I-type, lw and sw; 0 otherwise.
  - R-type alu_op by funct3: 000 → add (010) if funct7[5] = 0, sub (110) if funct7[5] = 1; 111 → and; 110 → or; 010 → slt.
  - I-type alu_op by funct3: 000 → add; 111 → and; 110 → or; 010 → slt. funct7 is ignored.
  - lw and sw use add; beq uses sub.
  - beq:
    - pc_we = 1.
    - pc_sel = 01 if zero = 1, else 00.
    - Next state FETCH.
  - lw and sw go to MEM.
  - R-type, I-type and jal go to WB.
- MEM:
  - mem_read = 1 for lw; mem_write = 1 for sw. The strobe is held until mem_ready = 1.
  - On mem_ready = 1:
    - lw goes to WB.
    - sw asserts pc_we = 1 with pc_sel = 00 and goes to FETCH.
- WB:
  - reg_write = 1.
  - pc_we = 1.
  - wb_sel = 01 for lw, 10 for jal, else 00.
  - pc_sel = 10 for jal, else 00.
  - Next state FETCH.
- TRAP:
  - illegal = 1 (sticky); all strobes 0.
  - Terminal until rst.
- pc_we is asserted exactly once per retired instruction, in that instruction's final cycle.
- A write to rd = x0 still asserts reg_write; the register file discards it.
- Latency with zero-wait memory (mem_ready tied to 1): R/I 4 cycles, lw 5, sw 4, beq 3, jal 4. Each memory wait cycle adds 1.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[31:0] and ret_cnt[31:0], both cleared by rst.
  - cyc_cnt increments every clock edge while not in TRAP.
  - ret_cnt increments in every cycle where pc_we = 1.
  - Both wrap modulo 2^32.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- rst pulse mid-EXEC of add → state = 0 and all strobes 0 before the next edge; after release, i_req = 1.
- mem_ready = 1, ins = 0x002081B3 (add x3,x1,x2) → states 0,1,2,4. alu_op = 010 and alu_src = 0 in EXEC; reg_write = 1, pc_we = 1, wb_sel = 00 in WB; 4 cycles total.
- ins = 0x0000A183 (lw x3,0(x1)), mem_ready low for 2 MEM cycles → mem_read held for 3 cycles, then WB with wb_sel = 01; 7 cycles total.
- ins = 0x00208463 (beq), zero = 1, then zero = 0 → EXEC asserts pc_we with pc_sel = 01, then 00; 3 cycles each.
- ins = 0x0000007F (illegal opcode) → DECODE → TRAP; illegal = 1 holds for 20+ cycles with no strobes until rst.
- With MULTICYCLE_CTRL_PERF_EN defined, sequence add, sw, beq at zero-wait → ret_cnt = 3, cyc_cnt = 11.
